// File: rtl/score_pkg.sv
// Shared types and constants for the score BCD converter.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Largest value representable in the given number of decimal digits (10^digits - 1).
    function automatic longint unsigned max_value(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_add3_cell (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Pure combinational correction.
    always_comb begin
        nib_out = nib_in;
        if (nib_in >= 4'd5) begin
            nib_out = nib_in + 4'd3;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter for one on-screen number field.
// Produces held decimal digits, a leading-zero draw mask and a saturation flag.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | waiting for start; outputs hold the last result
//  ST_SHIFT | one add-3/shift step per clock, BIN_WIDTH steps in total
//  ST_DONE  | publish digits/mask/overflow, pulse done, back to idle
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       value_in,
    output logic [DIGITS-1:0][3:0]     digit,
    output logic [DIGITS-1:0]          digit_en,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int              BCD_W    = DIGITS * 4;
    localparam int              CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned MAX_VAL  = max_value(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e                   state_q, state_d;
    logic [BIN_WIDTH-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sat_q, sat_d;
    logic [DIGITS-1:0][3:0]   digit_q, digit_d;
    logic [DIGITS-1:0]        digit_en_q, digit_en_d;
    logic                     overflow_q, overflow_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [BCD_W-1:0]         bcd_adj;
    logic                     bcd_carry_unused;
    logic [DIGITS-1:0]        lz_mask;
    logic                     seen_nz;
    logic                     sat_in;

    // Per-nibble add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .nib_in  (bcd_q[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    // The carry out of the top decade is dropped; the saturation path covers those values.
    assign bcd_carry_unused = bcd_adj[BCD_W-1];

    assign sat_in = (64'(value_in) > MAX_VAL);

    // Leading-zero mask: a digit is drawn if it or any more significant digit is non-zero; units always drawn.
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz    = seen_nz | (bcd_q[4*i +: 4] != 4'd0);
            lz_mask[i] = seen_nz | (i == 0);
        end
    end

    // Next-state and datapath computation.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        digit_d    = digit_q;
        digit_en_d = digit_en_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = value_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_LOAD;
                    sat_d   = sat_in;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (sat_q) begin
                    digit_d    = {DIGITS{4'd9}};
                    digit_en_d = '1;
                end else begin
                    digit_d    = bcd_q;
                    digit_en_d = lz_mask;
                end
                overflow_d = sat_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any conversion without a done pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            digit_q    <= '0;
            digit_en_q <= DIGITS'(1);
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            digit_q    <= digit_d;
            digit_en_q <= digit_en_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign digit    = digit_q;
    assign digit_en = digit_en_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: stimulus queues expected results,
// a monitor pops and compares on every done pulse.
module tb_score_bcd_converter;

    localparam int DIGITS    = 3;
    localparam int BIN_WIDTH = 10;
    localparam int LATENCY   = BIN_WIDTH + 1;

    logic                   clk = 1'b0;
    logic                   resetN;
    logic                   start;
    logic [BIN_WIDTH-1:0]   value_in;
    logic [DIGITS-1:0][3:0] digit;
    logic [DIGITS-1:0]      digit_en;
    logic                   overflow;
    logic                   busy;
    logic                   done;

    typedef struct {
        logic [11:0] dig;
        logic [2:0]  en;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          done_seen = 0;
    int          busy_cnt  = 0;
    logic [11:0] held      = '0;

    score_bcd_converter #(
        .DIGITS    (DIGITS),
        .BIN_WIDTH (BIN_WIDTH)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start),
        .value_in (value_in),
        .digit    (digit),
        .digit_en (digit_en),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every done pulse against the scoreboard and guards output stability.
    always @(negedge clk) begin
        if (!resetN) begin
            busy_cnt = 0;
            held     = digit;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h required=no_done", digit);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("digit",    32'(digit),    32'(e.dig));
                    chk("digit_en", 32'(digit_en), 32'(e.en));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    chk("latency",  32'(cyc),      32'(e.due));
                    chk("busy_len", 32'(busy_cnt), 32'(LATENCY));
                    chk("busy_in_done", 32'(busy), 32'd0);
                end
                held     = digit;
                busy_cnt = 0;
            end else begin
                chk("digit_hold", 32'(digit), 32'(held));
            end
        end
    end

    // Called just after a falling edge; start is seen on the next rising edge.
    task automatic issue(input logic [9:0] v, input logic [11:0] d, input logic [2:0] en,
                         input logic ovf, input bit accept);
        start    = 1'b1;
        value_in = v;
        if (accept) sb.push_back('{d, en, ovf, cyc + 1 + LATENCY});
        @(negedge clk);
        #1;
        start    = 1'b0;
        value_in = ~v;
    endtask

    task automatic wait_done();
        int n0;
        int k;
        n0 = done_seen;
        k  = 0;
        while (done_seen == n0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (done_seen == n0) begin
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_40");
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_digit",    32'(digit),    32'h000);
        chk("rst_digit_en", 32'(digit_en), 32'b001);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
    endtask

    initial begin
        resetN   = 1'b0;
        start    = 1'b0;
        value_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals();
        resetN = 1'b1;
        @(negedge clk);
        #1;

        issue(10'd0,    12'h000, 3'b001, 1'b0, 1'b1); wait_done();
        issue(10'd987,  12'h987, 3'b111, 1'b0, 1'b1); wait_done();
        issue(10'd45,   12'h045, 3'b011, 1'b0, 1'b1); wait_done();
        issue(10'd1023, 12'h999, 3'b111, 1'b1, 1'b1); wait_done();
        issue(10'd999,  12'h999, 3'b111, 1'b0, 1'b1); wait_done();
        issue(10'd100,  12'h100, 3'b111, 1'b0, 1'b1); wait_done();

        // A start during the conversion must be dropped.
        issue(10'd123, 12'h123, 3'b111, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        issue(10'd456, 12'h000, 3'b000, 1'b0, 1'b0);
        wait_done();
        // Now inside the done cycle: this start must be accepted.
        issue(10'd456, 12'h456, 3'b111, 1'b0, 1'b1);
        wait_done();

        // Abort a conversion of 500 part-way with reset.
        issue(10'd500, 12'h500, 3'b111, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        resetN = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        #1;
        issue(10'd7, 12'h007, 3'b001, 1'b0, 1'b1); wait_done();

        repeat (15) @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
